// File: rtl/alarm_ctrl_pkg.sv
// alarm_ctrl_pkg: shared state encoding, set_mode codes and counter sizing for the alarm controller
package alarm_ctrl_pkg;
  typedef enum logic [2:0] {RUN, SET_H, SET_M, RING, SNOOZE} state_t;
  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SET_H = 2'd1;
  localparam logic [1:0] MODE_SET_M = 2'd2;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alarm_ctrl_fsm_if.sv
// alarm_ctrl_fsm_if: buttons and current time in, alarm programming and ring status out
interface alarm_ctrl_fsm_if #(
  parameter int HOUR_W = 2,
  parameter int MIN_W  = 3,
  parameter int SEC_W  = 2
);
  logic              tick;
  logic              mode_btn;
  logic              inc_btn;
  logic              snooze_btn;
  logic [HOUR_W-1:0] cur_hours;
  logic [MIN_W-1:0]  cur_minutes;
  logic [SEC_W-1:0]  cur_seconds;
  logic [HOUR_W-1:0] alarm_hours;
  logic [MIN_W-1:0]  alarm_minutes;
  logic              armed;
  logic [1:0]        set_mode;
  logic              ring;
  logic              snoozing;
  modport master (
    output tick, mode_btn, inc_btn, snooze_btn, cur_hours, cur_minutes, cur_seconds,
    input  alarm_hours, alarm_minutes, armed, set_mode, ring, snoozing
  );
  modport slave (
    input  tick, mode_btn, inc_btn, snooze_btn, cur_hours, cur_minutes, cur_seconds,
    output alarm_hours, alarm_minutes, armed, set_mode, ring, snoozing
  );
endinterface

// File: rtl/btn_edge.sv
// btn_edge: one event per rising edge of a synchronous level input
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic ev
);
  logic prev;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) prev <= 1'b0;
    else prev <= btn;
  assign ev = btn & ~prev;
endmodule

// File: rtl/alarm_ctrl_fsm.sv
// alarm_ctrl_fsm: button-driven alarm programming plus ring / snooze / dismiss sequencing
module alarm_ctrl_fsm
  import alarm_ctrl_pkg::*;
#(
  parameter int HOUR_W       = 2,
  parameter int MIN_W        = 3,
  parameter int SEC_W        = 2,
  parameter int HOUR_MAX     = 3,
  parameter int MIN_MAX      = 7,
  parameter int SNOOZE_TICKS = 8,
  parameter int RING_TICKS   = 12
) (
  input logic clk,
  input logic rst_n,
  alarm_ctrl_fsm_if.slave bus
);
  localparam int RC_W = cnt_w(RING_TICKS);
  localparam int SC_W = cnt_w(SNOOZE_TICKS);
  state_t st, st_n;
  logic [HOUR_W-1:0] ah, ah_n;
  logic [MIN_W-1:0] am, am_n;
  logic arm, arm_n, ring, snz;
  logic [1:0] mode;
  logic [RC_W-1:0] rc, rc_n;
  logic [SC_W-1:0] sc, sc_n;
  logic mode_ev, inc_ev, snz_ev, match;
  btn_edge u_mode (.clk(clk), .rst_n(rst_n), .btn(bus.mode_btn), .ev(mode_ev));
  btn_edge u_inc (.clk(clk), .rst_n(rst_n), .btn(bus.inc_btn), .ev(inc_ev));
  btn_edge u_snz (.clk(clk), .rst_n(rst_n), .btn(bus.snooze_btn), .ev(snz_ev));
  // seconds==0 keeps the compare from re-firing for the rest of the match minute
  assign match = bus.tick && bus.cur_hours == ah && bus.cur_minutes == am &&
                 bus.cur_seconds == {SEC_W{1'b0}};
  always_comb begin
    st_n = st;
    ah_n = ah;
    am_n = am;
    arm_n = arm;
    rc_n = rc;
    sc_n = sc;
    case (st)
      RUN:
        if (mode_ev) st_n = SET_H;
        else if (inc_ev) arm_n = ~arm;
        else if (arm && match) begin
          st_n = RING;
          rc_n = '0;
        end
      SET_H:
        if (mode_ev) st_n = SET_M;
        else if (inc_ev) ah_n = ah == HOUR_W'(HOUR_MAX) ? '0 : ah + 1'b1;
      SET_M:
        if (mode_ev) begin
          st_n = RUN;
          arm_n = 1'b1;
        end else if (inc_ev) am_n = am == MIN_W'(MIN_MAX) ? '0 : am + 1'b1;
      RING:
        if (mode_ev) st_n = RUN;
        else if (snz_ev) begin
          st_n = SNOOZE;
          sc_n = SC_W'(SNOOZE_TICKS - 1);
        end else if (bus.tick) begin
          if (rc == RC_W'(RING_TICKS - 1)) st_n = RUN;
          else rc_n = rc + 1'b1;
        end
      SNOOZE:
        if (mode_ev) st_n = RUN;
        else if (bus.tick) begin
          if (sc == '0) begin
            st_n = RING;
            rc_n = '0;
          end else sc_n = sc - 1'b1;
        end
      default: st_n = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      st <= RUN;
      ah <= '0;
      am <= '0;
      arm <= 1'b0;
      rc <= '0;
      sc <= '0;
      ring <= 1'b0;
      snz <= 1'b0;
      mode <= MODE_RUN;
    end else begin
      st <= st_n;
      ah <= ah_n;
      am <= am_n;
      arm <= arm_n;
      rc <= rc_n;
      sc <= sc_n;
      ring <= st_n == RING;
      snz <= st_n == SNOOZE;
      mode <= st_n == SET_H ? MODE_SET_H : st_n == SET_M ? MODE_SET_M : MODE_RUN;
    end
  assign bus.alarm_hours = ah;
  assign bus.alarm_minutes = am;
  assign bus.armed = arm;
  assign bus.set_mode = mode;
  assign bus.ring = ring;
  assign bus.snoozing = snz;
endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// tb_alarm_ctrl_fsm: scoreboard bench for programming, wrap, ring timeout, snooze and async reset
module tb_alarm_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    string tag;
    logic [9:0] exp;
  } sb_t;
  sb_t sb[$];
  alarm_ctrl_fsm_if bus ();
  alarm_ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [9:0] obs();
    return {bus.alarm_hours, bus.alarm_minutes, bus.armed, bus.set_mode, bus.ring, bus.snoozing};
  endfunction
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got h=%0d m=%0d arm=%0d mode=%0d ring=%0d snz=%0d, want h=%0d m=%0d arm=%0d mode=%0d ring=%0d snz=%0d",
                  tag, got[9:8], got[7:5], got[4], got[3:2], got[1], got[0],
                  exp[9:8], exp[7:5], exp[4], exp[3:2], exp[1], exp[0]);
  endtask
  task automatic expect_out(input string tag, input int h, input int m, input int a,
                            input int md, input int r, input int s);
    sb_t e;
    e.tag = tag;
    e.exp = {2'(h), 3'(m), 1'(a), 2'(md), 1'(r), 1'(s)};
    sb.push_back(e);
  endtask
  task automatic compare_out();
    sb_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: got empty queue, want an expected entry");
    end else begin
      e = sb.pop_front();
      check(e.tag, obs(), e.exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input bit m, input bit i, input bit s);
    bus.mode_btn = m;
    bus.inc_btn = i;
    bus.snooze_btn = s;
    cyc(1);
    bus.mode_btn = 1'b0;
    bus.inc_btn = 1'b0;
    bus.snooze_btn = 1'b0;
    cyc(2);
  endtask
  task automatic ticks(input int n, input int h, input int m, input int s);
    bus.cur_hours = 2'(h);
    bus.cur_minutes = 3'(m);
    bus.cur_seconds = 2'(s);
    bus.tick = 1'b1;
    cyc(n);
    bus.tick = 1'b0;
  endtask
  initial begin
    rst_n = 1'b1;
    bus.tick = 1'b0;
    bus.mode_btn = 1'b0;
    bus.inc_btn = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.cur_hours = '0;
    bus.cur_minutes = '0;
    bus.cur_seconds = '0;
    cyc(2);
    expect_out("reset", 0, 0, 0, 0, 0, 0); compare_out();
    rst_n = 1'b0;
    cyc(2);
    pulse(1, 0, 0);
    expect_out("enter_set_h", 0, 0, 0, 1, 0, 0); compare_out();
    repeat (2) pulse(0, 1, 0);
    expect_out("hours_2", 2, 0, 0, 1, 0, 0); compare_out();
    pulse(1, 0, 0);
    expect_out("enter_set_m", 2, 0, 0, 2, 0, 0); compare_out();
    repeat (5) pulse(0, 1, 0);
    expect_out("minutes_5", 2, 5, 0, 2, 0, 0); compare_out();
    pulse(1, 0, 0);
    expect_out("prog_arms", 2, 5, 1, 0, 0, 0); compare_out();
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    expect_out("hours_3", 3, 5, 1, 1, 0, 0); compare_out();
    pulse(0, 1, 0);
    expect_out("hours_wrap", 0, 5, 1, 1, 0, 0); compare_out();
    pulse(0, 1, 0);
    expect_out("hours_1", 1, 5, 1, 1, 0, 0); compare_out();
    pulse(1, 0, 0);
    repeat (2) pulse(0, 1, 0);
    expect_out("minutes_7", 1, 7, 1, 2, 0, 0); compare_out();
    pulse(0, 1, 0);
    expect_out("minutes_wrap", 1, 0, 1, 2, 0, 0); compare_out();
    repeat (3) pulse(0, 1, 0);
    pulse(1, 0, 0);
    expect_out("alarm_1_3", 1, 3, 1, 0, 0, 0); compare_out();
    ticks(1, 1, 3, 0);
    expect_out("ring_start", 1, 3, 1, 0, 1, 0); compare_out();
    ticks(11, 1, 3, 1);
    expect_out("ring_11", 1, 3, 1, 0, 1, 0); compare_out();
    ticks(1, 1, 3, 1);
    expect_out("ring_timeout", 1, 3, 1, 0, 0, 0); compare_out();
    ticks(5, 1, 3, 2);
    expect_out("no_retrigger", 1, 3, 1, 0, 0, 0); compare_out();
    ticks(1, 1, 3, 0);
    expect_out("ring_again", 1, 3, 1, 0, 1, 0); compare_out();
    bus.cur_seconds = 2'd1;
    pulse(0, 0, 1);
    expect_out("snooze", 1, 3, 1, 0, 0, 1); compare_out();
    ticks(7, 1, 3, 1);
    expect_out("snooze_7", 1, 3, 1, 0, 0, 1); compare_out();
    ticks(1, 1, 3, 1);
    expect_out("snooze_end", 1, 3, 1, 0, 1, 0); compare_out();
    pulse(1, 0, 0);
    expect_out("dismiss", 1, 3, 1, 0, 0, 0); compare_out();
    pulse(1, 1, 0);
    expect_out("mode_over_inc", 1, 3, 1, 1, 0, 0); compare_out();
    bus.inc_btn = 1'b1;
    cyc(20);
    bus.inc_btn = 1'b0;
    cyc(2);
    expect_out("held_inc", 2, 3, 1, 1, 0, 0); compare_out();
    repeat (2) pulse(1, 0, 0);
    expect_out("back_run", 2, 3, 1, 0, 0, 0); compare_out();
    pulse(0, 1, 0);
    expect_out("disarm", 2, 3, 0, 0, 0, 0); compare_out();
    ticks(1, 2, 3, 0);
    expect_out("disarmed_match", 2, 3, 0, 0, 0, 0); compare_out();
    pulse(0, 1, 0);
    expect_out("rearm", 2, 3, 1, 0, 0, 0); compare_out();
    ticks(1, 2, 3, 0);
    expect_out("ring_pre_rst", 2, 3, 1, 0, 1, 0); compare_out();
    #2 rst_n = 1'b1;
    #1;
    expect_out("async_reset", 0, 0, 0, 0, 0, 0); compare_out();
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl_fsm.md
Name: alarm_ctrl_fsm

Overview:
Control/configuration sequencer for the alarm clock counter block. Uses three button inputs to program the alarm time and to arm or disarm the alarm. Watches the running time (hours/minutes/seconds) and drives the ring / snooze / dismiss sequence. Sits between the user buttons and the clock counter; it owns the alarm_hours/alarm_minutes registers that feed the counter's compare.

Parameters:
HOUR_W, 2, width of hour fields
MIN_W, 3, width of minute fields
SEC_W, 2, width of seconds field
HOUR_MAX, 3, last valid hour value; wraps to 0 after it
MIN_MAX, 7, last valid minute value; wraps to 0 after it
SNOOZE_TICKS, 8, snooze duration in ticks (>=1)
RING_TICKS, 12, auto-stop ring duration in ticks (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
tick  in  1  1-cycle enable, coincident with the clock counter advancing
mode_btn  in  1  level, already synchronous to clk
inc_btn  in  1  level, already synchronous
snooze_btn  in  1  level, already synchronous
cur_hours  in  HOUR_W  current time from the counter
cur_minutes  in  MIN_W  current time
cur_seconds  in  SEC_W  current time
alarm_hours  out  HOUR_W  programmed alarm hour
alarm_minutes  out  MIN_W  programmed alarm minute
armed  out  1  alarm enabled
set_mode  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=unused
ring  out  1  alarm sounding
snoozing  out  1  snooze countdown active

Behaviour:
- Reset (async, rst_n=1): state RUN, alarm_hours=0, alarm_minutes=0, armed=0, ring=0, snoozing=0, set_mode=0, all counters and edge-detect history = 0.
- Edge detection: every button is rising-edge detected (prev register per button). A held button produces exactly one event. Events act in the cycle after the rising edge is registered, i.e. 1-cycle latency from the input edge to the state/register update.
- Priority within a cycle: mode_ev > snooze_ev > inc_ev > tick-driven transitions.
- RUN:
  - mode_ev -> SET_H.
  - inc_ev toggles armed.
  - If armed && tick && cur_hours==alarm_hours && cur_minutes==alarm_minutes && cur_seconds==0 -> RING, ring_cnt=0.
- SET_H:
  - inc_ev: alarm_hours += 1; HOUR_MAX wraps to 0.
  - mode_ev -> SET_M.
  - Time matches are ignored (no ring in SET states).
- SET_M:
  - inc_ev: alarm_minutes += 1; MIN_MAX wraps to 0.
  - mode_ev -> RUN and sets armed=1 (programming always arms).
- RING:
  - snooze_ev -> SNOOZE, snz_cnt=SNOOZE_TICKS-1.
  - mode_ev -> RUN (dismiss); armed is unchanged.
  - On tick: if ring_cnt==RING_TICKS-1 -> RUN, else ring_cnt+1.
  - inc_ev is ignored.
- SNOOZE:
  - On tick: if snz_cnt==0 -> RING with ring_cnt=0, else snz_cnt-1.
  - mode_ev -> RUN (dismiss).
  - snooze_ev and inc_ev are ignored.
- Outputs are registered:
  - ring=1 exactly while state==RING.
  - snoozing=1 exactly while state==SNOOZE.
  - set_mode encodes RUN/SET_H/SET_M; it reads 0 in RING and SNOOZE.
- Re-trigger: matching requires cur_seconds==0, so after a dismiss or timeout the alarm does not restart within the same minute value. A SNOOZE wait that ends still inside the match minute re-enters RING via the counter, not via the compare.
- Counters are sized to clog2 of their parameter, with a minimum width of 1; no arithmetic overflow beyond the compares above.
- Asserting reset mid-ring or mid-set returns to the reset state immediately. Partially programmed alarm values are lost.

Decomposition:
- Shared package alarm_ctrl_pkg: state enum (RUN, SET_H, SET_M, RING, SNOOZE), set_mode encoding constants (MODE_RUN=0, MODE_SET_H=1, MODE_SET_M=2).
- One sub-module btn_edge: 1-bit rising-edge detector with async active-high reset, instantiated three times.

Test Plan:
- Reset, then mode, inc×2, mode, inc×5, mode (one pulse each, gaps >=2 cycles) -> alarm_hours=2, alarm_minutes=5, armed=1, set_mode back to 0.
- In SET_H with alarm_hours=3, inc pulse -> alarm_hours=0. In SET_M with alarm_minutes=7, inc pulse -> alarm_minutes=0.
- Armed, alarm 1:3, drive cur=1:3:0 with tick -> ring=1 next cycle. With no buttons, after 12 ticks ring=0 and state RUN. Continued ticks in minute 1:3 with seconds≠0 do not re-ring.
- Ringing, snooze pulse -> ring=0, snoozing=1. After 8 ticks -> ring=1, snoozing=0. Then mode pulse -> ring=0, armed still 1.
- mode and inc rising in the same cycle while in RUN -> state SET_H, armed unchanged. inc held high for 20 cycles -> exactly one increment.
- armed=0 with a matching time on tick -> ring stays 0. Reset asserted while ring=1 -> ring=0 and alarm_hours=0 immediately, without waiting for a clock edge.
